// File: rtl/grid_scan_driver.sv
// Double-buffered 8x8 LED matrix row-scan driver fed by a valid/ready grid bus.
// Optional build macro SCAN_BLANK_EN inserts BLANK_CYCLES dark cycles after every row.
module grid_scan_driver #(
   parameter int DWELL        = 4,
   parameter int BLANK_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] grid_in,
   input  logic        grid_valid,
   output logic        grid_ready,
   input  logic        enable,
   output logic [7:0]  row_sel,
   output logic [7:0]  col_data,
   output logic        frame_done
);

   // state | meaning
   // IDLE  | matrix dark, waiting for enable and a pending frame
   // SCAN  | row `row` of shadow driven for DWELL cycles
   // BLANK | matrix dark for BLANK_CYCLES after a row (SCAN_BLANK_EN only)
   typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

   localparam logic [15:0] DWELL_TC = 16'(DWELL - 1);
   localparam logic [15:0] BLANK_TC = 16'(BLANK_CYCLES - 1);

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [2:0]  row, row_nxt;
   logic [63:0] pending, shadow;
   logic        pending_full;
   logic        phase_end, adv, consume, frame_end;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      row_nxt   = row;
      adv       = 1'b0;
      consume   = 1'b0;
      frame_end = 1'b0;
      phase_end = (cnt == ((state == BLANK) ? BLANK_TC : DWELL_TC));
      case (state)
         IDLE: begin
            if (enable && pending_full) begin
               consume   = 1'b1;
               state_nxt = SCAN;
               cnt_nxt   = 16'd0;
               row_nxt   = 3'd0;
            end
         end
         SCAN: begin
            if (phase_end) begin
               cnt_nxt = 16'd0;
`ifdef SCAN_BLANK_EN
               state_nxt = BLANK;
`else
               adv = 1'b1;
`endif
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         BLANK: begin
            if (phase_end) begin
               cnt_nxt   = 16'd0;
               state_nxt = SCAN;
               adv       = 1'b1;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Row advance; the frame boundary is the only place the shadow may change.
      if (adv) begin
         row_nxt = row + 3'd1;
         if (row == 3'd7) begin
            frame_end = 1'b1;
            if (!enable)
               state_nxt = IDLE;
            else if (pending_full)
               consume = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= 16'd0;
         row          <= 3'd0;
         pending      <= 64'd0;
         shadow       <= 64'd0;
         pending_full <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         row        <= row_nxt;
         frame_done <= frame_end;
         if (grid_valid && !pending_full) begin
            pending      <= grid_in;
            pending_full <= 1'b1;
         end else if (consume) begin
            pending_full <= 1'b0;
         end
         if (consume)
            shadow <= pending;
      end
   end

   assign grid_ready = !pending_full;
   assign row_sel    = (state == SCAN) ? (8'd1 << row) : 8'd0;
   assign col_data   = (state == SCAN) ? shadow[{row, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_grid_scan_driver.sv
// Directed bench for grid_scan_driver: reset, frame scan, double buffering, enable stop, mid-frame reset.
module tb_grid_scan_driver;

   localparam int DW = 4;
`ifdef SCAN_BLANK_EN
   localparam int BL = 2;
`else
   localparam int BL = 0;
`endif
   localparam int RP = DW + BL;
   localparam int P  = 8 * RP;

   localparam logic [63:0] G1 = 64'h0412_6424_0034_3C28;
   localparam logic [63:0] G2 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] G3 = 64'h1122_3344_5566_7788;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] grid_in;
   logic        grid_valid;
   logic        grid_ready;
   logic        enable;
   logic [7:0]  row_sel;
   logic [7:0]  col_data;
   logic        frame_done;

   int vecs = 0;
   int errs = 0;

   grid_scan_driver #(.DWELL(DW), .BLANK_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .grid_in(grid_in), .grid_valid(grid_valid),
      .grid_ready(grid_ready), .enable(enable), .row_sel(row_sel),
      .col_data(col_data), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs at cycle k of a frame (k=0 is the first cycle of row 0).
   function automatic logic [7:0] exp_sel(int k);
      if (k % RP < DW) return 8'(1 << (k / RP));
      return 8'd0;
   endfunction

   function automatic logic [7:0] exp_col(logic [63:0] g, int k);
      logic [63:0] t;
      t = g;
      if (k % RP < DW) return t[(k / RP) * 8 +: 8];
      return 8'd0;
   endfunction

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; grid_valid = 1'b0; grid_in = 64'd0;
      tick(); tick();
      reset = 1'b0;
      vecs++;
      if (row_sel !== 8'd0 || col_data !== 8'd0 || grid_ready !== 1'b1 || frame_done !== 1'b0) begin
         errs++;
         $display("FAIL reset_state: sel=%h col=%h rdy=%b fd=%b, want 00 00 1 0", row_sel, col_data, grid_ready, frame_done);
      end
      enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         vecs++;
         if (row_sel !== 8'd0 || col_data !== 8'd0 || grid_ready !== 1'b1 || frame_done !== 1'b0) begin
            errs++;
            $display("FAIL idle_no_frame cyc %0d: sel=%h col=%h rdy=%b fd=%b, want 00 00 1 0", i, row_sel, col_data, grid_ready, frame_done);
         end
      end
   endtask

   task automatic test_first_frame();
      grid_in = G1; grid_valid = 1'b1;
      tick();
      vecs++;
      if (grid_ready !== 1'b0 || row_sel !== 8'd0) begin
         errs++;
         $display("FAIL handshake_e0: rdy=%b sel=%h, want 0 00", grid_ready, row_sel);
      end
      grid_valid = 1'b0;
      tick();
      for (int k = 0; k < P; k++) begin
         vecs++;
         if (row_sel !== exp_sel(k) || col_data !== exp_col(G1, k) || frame_done !== 1'b0) begin
            errs++;
            $display("FAIL first_frame k=%0d: sel=%h col=%h fd=%b, want %h %h 0", k, row_sel, col_data, frame_done, exp_sel(k), exp_col(G1, k));
         end
         tick();
      end
   endtask

   task automatic test_rescan();
      for (int k = 0; k < P; k++) begin
         vecs++;
         if (row_sel !== exp_sel(k) || col_data !== exp_col(G1, k) || frame_done !== (k == 0)) begin
            errs++;
            $display("FAIL rescan k=%0d: sel=%h col=%h fd=%b, want %h %h %b", k, row_sel, col_data, frame_done, exp_sel(k), exp_col(G1, k), k == 0);
         end
         if (k == 10) begin
            vecs++;
            if (grid_ready !== 1'b0) begin
               errs++;
               $display("FAIL ready_drop: rdy=%b, want 0", grid_ready);
            end
            grid_valid = 1'b0;
         end
         if (k == 9) begin
            grid_in = G2; grid_valid = 1'b1;
         end
         if (k == P - 3) begin
            grid_in = G3; grid_valid = 1'b1;
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      vecs++;
      if (grid_ready !== 1'b1) begin
         errs++;
         $display("FAIL boundary_no_transfer: rdy=%b, want 1", grid_ready);
      end
      grid_valid = 1'b0;
      for (int k = 0; k < P; k++) begin
         vecs++;
         if (row_sel !== exp_sel(k) || col_data !== exp_col(G2, k) || frame_done !== (k == 0)) begin
            errs++;
            $display("FAIL second_frame k=%0d: sel=%h col=%h fd=%b, want %h %h %b", k, row_sel, col_data, frame_done, exp_sel(k), exp_col(G2, k), k == 0);
         end
         tick();
      end
   endtask

   task automatic test_enable_stop();
      for (int k = 0; k < P; k++) begin
         vecs++;
         if (row_sel !== exp_sel(k) || col_data !== exp_col(G2, k) || frame_done !== (k == 0)) begin
            errs++;
            $display("FAIL enable_cancel k=%0d: sel=%h col=%h fd=%b, want %h %h %b", k, row_sel, col_data, frame_done, exp_sel(k), exp_col(G2, k), k == 0);
         end
         if (k == 2 * RP) enable = 1'b0;
         if (k == 5 * RP) enable = 1'b1;
         tick();
      end
      for (int k = 0; k < P; k++) begin
         vecs++;
         if (row_sel !== exp_sel(k) || col_data !== exp_col(G2, k) || frame_done !== (k == 0)) begin
            errs++;
            $display("FAIL enable_stop k=%0d: sel=%h col=%h fd=%b, want %h %h %b", k, row_sel, col_data, frame_done, exp_sel(k), exp_col(G2, k), k == 0);
         end
         if (k == 3 * RP) enable = 1'b0;
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         vecs++;
         if (row_sel !== 8'd0 || col_data !== 8'd0 || frame_done !== (i == 0)) begin
            errs++;
            $display("FAIL stopped_idle cyc %0d: sel=%h col=%h fd=%b, want 00 00 %b", i, row_sel, col_data, frame_done, i == 0);
         end
         tick();
      end
   endtask

   task automatic test_reset_midframe();
      enable = 1'b1; grid_in = G1; grid_valid = 1'b1;
      tick();
      grid_valid = 1'b0;
      tick();
      for (int k = 0; k <= 5 * RP; k++) begin
         vecs++;
         if (row_sel !== exp_sel(k) || col_data !== exp_col(G1, k)) begin
            errs++;
            $display("FAIL pre_reset k=%0d: sel=%h col=%h, want %h %h", k, row_sel, col_data, exp_sel(k), exp_col(G1, k));
         end
         if (k == 3) begin
            vecs++;
            if (grid_ready !== 1'b0) begin
               errs++;
               $display("FAIL pending_loaded: rdy=%b, want 0", grid_ready);
            end
            grid_valid = 1'b0;
         end
         if (k == 2) begin
            grid_in = G2; grid_valid = 1'b1;
         end
         if (k == 5 * RP) reset = 1'b1;
         tick();
      end
      vecs++;
      if (row_sel !== 8'd0 || col_data !== 8'd0 || frame_done !== 1'b0 || grid_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_midframe: sel=%h col=%h fd=%b rdy=%b, want 00 00 0 1", row_sel, col_data, frame_done, grid_ready);
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         vecs++;
         if (row_sel !== 8'd0 || col_data !== 8'd0 || grid_ready !== 1'b1) begin
            errs++;
            $display("FAIL pending_discarded cyc %0d: sel=%h col=%h rdy=%b, want 00 00 1", i, row_sel, col_data, grid_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_rescan();
      test_back_to_back();
      test_enable_stop();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
